// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, arbiter
// state encoding and an index-width helper that never returns zero.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority search: returns the first asserted request found when
// scanning from rr_ptr upward and wrapping modulo NUM_REQ.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int pos;

    // Scan every offset from the pointer; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing one UART TX serializer among
// NUM_REQ byte streams. An owner keeps the serializer until it ends its
// burst (req_last, valid dropping, or MAX_BURST bytes); the arbiter then
// waits for the line to go idle so each source's bytes stay contiguous.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_W    = UART_DATA_W,
    parameter int  MAX_BURST = 4,
    localparam int IDX_W     = idx_width(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    input  logic                      tx_busy,
    output logic                      grant_active,
    output logic [IDX_W-1:0]          grant_id
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic             grant_active_q, grant_active_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    logic              in_xfer;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              accept;
    logic              end_of_burst;
    logic [IDX_W-1:0]  next_ptr;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Decode the current owner's request lines and the release conditions.
    always_comb begin
        in_xfer      = (state_q == XFER);
        owner_valid  = req_valid[grant_id_q];
        owner_last   = req_last[grant_id_q];
        owner_data   = req_data[grant_id_q*DATA_W +: DATA_W];
        accept       = in_xfer && owner_valid && tx_ready;
        // req_last and the burst cap may coincide; either one ends the burst.
        end_of_burst = owner_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1));
        if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id_q + IDX_W'(1);
        end
    end

    // Owner's handshake passes straight through to the serializer in XFER.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (in_xfer) begin
            tx_valid              = owner_valid;
            tx_data               = owner_data;
            req_ready[grant_id_q] = tx_ready;
        end
        grant_active = grant_active_q;
        grant_id     = grant_id_q;
    end

    // Next-state logic for the IDLE -> XFER -> DRAIN -> IDLE cycle.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        burst_cnt_d    = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d     = pick_idx;
                    burst_cnt_d    = '0;
                    grant_active_d = 1'b1;
                    state_d        = XFER;
                end
            end
            XFER: begin
                // A dropped valid ends the burst without moving a byte.
                if (!owner_valid || (accept && end_of_burst)) begin
                    state_d     = DRAIN;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Hold ownership until the line is idle so bursts never mix.
                if (!tx_busy) begin
                    state_d        = IDLE;
                    grant_active_d = 1'b0;
                end
            end
            default: begin
                state_d        = IDLE;
                grant_active_d = 1'b0;
            end
        endcase
    end

    // Arbiter state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            burst_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            burst_cnt_q    <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a driver issues bytes per requester
// (pushing each into that requester's expected queue), and an independent
// monitor checks grants, pass-through, bursts and drains against the
// round-robin rules, popping expected bytes as the serializer accepts them.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int IDX_W     = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic                      tx_busy;
    logic                      grant_active;
    logic [IDX_W-1:0]          grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester scanning rr, rr+1, ... mod N.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int rr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- driver / scoreboard producer ----------------
    logic [DATA_W:0]    script_q [NUM_REQ][$];
    logic [DATA_W:0]    exp_q    [NUM_REQ][$];
    logic [DATA_W-1:0]  cur_data [NUM_REQ];
    logic [NUM_REQ-1:0] cur_vld  = '0;
    logic [NUM_REQ-1:0] cur_last = '0;
    logic [NUM_REQ-1:0] cont     = '0;
    int                 remaining[NUM_REQ];
    logic [NUM_REQ-1:0] rand_en  = '0;
    int                 ready_pct = 100;
    int                 busy_lo = 2, busy_hi = 2;
    bit                 stall55_en = 1'b0;
    int                 busy_cnt = 0;
    int                 stall_cnt = 0;
    logic [NUM_REQ-1:0] drv_acc;
    logic               drv_tx_acc;

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        tx_busy   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
            cur_data[i]  = '0;
        end
        forever begin
            @(negedge clk);
            drv_acc    = req_valid & req_ready;
            drv_tx_acc = tx_valid & tx_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cur_vld[i] && drv_acc[i]) begin
                    cur_vld[i] = 1'b0;
                    cont[i]    = !cur_last[i];
                end
                if (!cur_vld[i]) begin
                    if (script_q[i].size() > 0) begin
                        {cur_last[i], cur_data[i]} = script_q[i].pop_front();
                        cur_vld[i] = 1'b1;
                    end else if (rand_en[i] && ($urandom_range(99) < (cont[i] ? 95 : 30))) begin
                        if (remaining[i] == 0) remaining[i] = $urandom_range(6, 1);
                        remaining[i]--;
                        cur_data[i] = DATA_W'($urandom);
                        cur_last[i] = (remaining[i] == 0);
                        cur_vld[i]  = 1'b1;
                    end
                    if (cur_vld[i]) begin
                        exp_q[i].push_back({cur_last[i], cur_data[i]});
                        if (stall55_en && i == 1 && cur_data[i] == 8'h55) stall_cnt = 5;
                    end
                end
                req_valid[i] = cur_vld[i];
                req_last[i]  = cur_last[i];
                req_data[i*DATA_W +: DATA_W] = cur_data[i];
            end
            if (drv_tx_acc) busy_cnt = $urandom_range(busy_hi, busy_lo);
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt > 0);
            if (stall_cnt > 0) begin
                tx_ready = 1'b0;
                stall_cnt--;
            end else begin
                tx_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // ---------------- monitor / scoreboard consumer ----------------
    int              ph = 0;          // 0 idle, 1 owner transferring, 2 waiting for line idle
    int              nph;
    int              g_m = 0;
    int              seg_cnt = 0;
    int              seg_cyc = 0;
    int              m_rr = 0;
    bit              pend = 1'b0;
    int              pend_id = 0;
    bit              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int              stall_run = 0;
    int              stall55 = -1;
    bit              rel;
    logic [DATA_W:0] e;
    int              grant_log[$];
    int              len_log[$];
    int              cyc_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; m_rr = 0; pend = 1'b0; g_m = 0;
                prev_stall = 1'b0; stall_run = 0;
            end else begin
                if (ph == 0) begin
                    if (pend) begin
                        chk("grant_active_rise", 32'(grant_active), 32'd1);
                        chk("grant_id_pick", 32'(grant_id), 32'(pend_id));
                        g_m = pend_id; ph = 1; seg_cnt = 0; seg_cyc = 0; pend = 1'b0;
                        prev_stall = 1'b0; stall_run = 0;
                        grant_log.push_back(pend_id);
                    end else begin
                        chk("idle_grant_active", 32'(grant_active), 32'd0);
                        chk("idle_tx_valid", 32'(tx_valid), 32'd0);
                        chk("idle_req_ready", 32'(req_ready), 32'd0);
                        chk("idle_grant_id_hold", 32'(grant_id), 32'(g_m));
                        if (req_valid != '0) begin
                            pend    = 1'b1;
                            pend_id = rr_pick(req_valid, m_rr);
                        end
                    end
                end
                nph = ph;
                if (ph == 1) begin
                    rel = 1'b0;
                    seg_cyc++;
                    chk("xfer_grant_active", 32'(grant_active), 32'd1);
                    chk("xfer_grant_id", 32'(grant_id), 32'(g_m));
                    chk("xfer_tx_valid", 32'(tx_valid), 32'(req_valid[g_m]));
                    chk("xfer_req_ready", 32'(req_ready), tx_ready ? (32'd1 << g_m) : 32'd0);
                    if (req_valid[g_m])
                        chk("xfer_tx_data", 32'(tx_data), 32'(req_data[g_m*DATA_W +: DATA_W]));
                    if (prev_stall) begin
                        chk("stall_hold_valid", 32'(tx_valid), 32'd1);
                        chk("stall_hold_data", 32'(tx_data), 32'(prev_data));
                    end
                    prev_stall = tx_valid && !tx_ready;
                    prev_data  = tx_data;
                    if (!req_valid[g_m]) begin
                        rel = 1'b1;
                    end else if (tx_ready) begin
                        if (exp_q[g_m].size() == 0) begin
                            chk("sb_unexpected_byte", 32'(exp_q[g_m].size()), 32'd1);
                        end else begin
                            e = exp_q[g_m].pop_front();
                            chk("sb_tx_data", 32'(tx_data), 32'(e[DATA_W-1:0]));
                            seg_cnt++;
                            if (stall55_en && g_m == 1 && tx_data == 8'h55) stall55 = stall_run;
                            if (e[DATA_W] || seg_cnt == MAX_BURST) rel = 1'b1;
                        end
                        stall_run = 0;
                    end else begin
                        stall_run++;
                    end
                    if (rel) begin
                        m_rr = (g_m + 1) % NUM_REQ;
                        nph  = 2;
                        len_log.push_back(seg_cnt);
                        cyc_log.push_back(seg_cyc);
                    end
                end else if (ph == 2) begin
                    chk("drain_grant_active", 32'(grant_active), 32'd1);
                    chk("drain_tx_valid", 32'(tx_valid), 32'd0);
                    chk("drain_req_ready", 32'(req_ready), 32'd0);
                    if (!tx_busy) nph = 0;
                end
                ph = nph;
            end
        end
    end

    // ---------------- directed and random phases ----------------
    task automatic wait_quiet(input int max_cyc, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
            done = (cur_vld == '0) && (ph == 0) && !pend && !grant_active;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (script_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        len_log.delete();
        cyc_log.delete();
    endtask

    int found;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // All four continuously valid, no req_last: capped bursts in rr order.
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < 20; b++) script_q[i].push_back({1'b0, 8'(i * 32 + b)});
        wait_quiet(3000, "A_quiet");
        chk("A_grant_count", 32'(grant_log.size()), 32'd20);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("A_grant_order", 32'(grant_log[k]), 32'(k % NUM_REQ));
            if (k < len_log.size())   chk("A_burst_len", 32'(len_log[k]), 32'd4);
        end

        // Single requester, three-byte burst, long line busy afterwards.
        busy_lo = 10; busy_hi = 10;
        clear_logs();
        script_q[0].push_back({1'b0, 8'h41});
        script_q[0].push_back({1'b0, 8'h42});
        script_q[0].push_back({1'b1, 8'h43});
        wait_quiet(200, "B_quiet");
        chk("B_grant_count", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) chk("B_grant_id", 32'(grant_log[0]), 32'd0);
        if (len_log.size() > 0)   chk("B_len", 32'(len_log[0]), 32'd3);
        if (cyc_log.size() > 0)   chk("B_consecutive", 32'(cyc_log[0]), 32'd3);

        // After owner 0 the pointer sits at 1.
        busy_lo = 2; busy_hi = 2;
        clear_logs();
        script_q[0].push_back({1'b1, 8'h01});
        script_q[1].push_back({1'b1, 8'h02});
        wait_quiet(200, "B2_quiet");
        chk("B2_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 1) begin
            chk("B2_first", 32'(grant_log[0]), 32'd1);
            chk("B2_second", 32'(grant_log[1]), 32'd0);
        end

        // Pointer at 3, then requesters 2 and 3 together.
        script_q[2].push_back({1'b1, 8'h33});
        wait_quiet(200, "C0_quiet");
        clear_logs();
        script_q[2].push_back({1'b1, 8'h34});
        script_q[3].push_back({1'b1, 8'h35});
        wait_quiet(200, "C_quiet");
        chk("C_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 1) begin
            chk("C_first", 32'(grant_log[0]), 32'd3);
            chk("C_second", 32'(grant_log[1]), 32'd2);
        end

        // Five-cycle serializer stall on byte 0x55 mid-burst.
        stall55_en = 1'b1;
        clear_logs();
        script_q[1].push_back({1'b0, 8'h11});
        script_q[1].push_back({1'b0, 8'h55});
        script_q[1].push_back({1'b0, 8'h66});
        script_q[1].push_back({1'b0, 8'h77});
        script_q[1].push_back({1'b1, 8'h88});
        wait_quiet(300, "D_quiet");
        stall55_en = 1'b0;
        chk("D_stall_cycles", 32'(stall55), 32'd5);
        chk("D_grant_count", 32'(grant_log.size()), 32'd2);
        if (len_log.size() > 1) begin
            chk("D_len_first", 32'(len_log[0]), 32'd4);
            chk("D_len_second", 32'(len_log[1]), 32'd1);
        end

        // req_last on the fourth byte coincides with the burst cap.
        clear_logs();
        script_q[0].push_back({1'b0, 8'h01});
        script_q[0].push_back({1'b0, 8'h02});
        script_q[0].push_back({1'b0, 8'h03});
        script_q[0].push_back({1'b1, 8'h04});
        script_q[1].push_back({1'b1, 8'h09});
        wait_quiet(300, "E_quiet");
        chk("E_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 1) begin
            chk("E_first", 32'(grant_log[0]), 32'd0);
            chk("E_second", 32'(grant_log[1]), 32'd1);
        end
        if (len_log.size() > 0) chk("E_len", 32'(len_log[0]), 32'd4);

        // Random traffic with random stalls and line-busy times.
        rand_en = '1; ready_pct = 70; busy_lo = 0; busy_hi = 4;
        repeat (3000) @(posedge clk);

        // Asynchronous reset two bytes into a transfer.
        ready_pct = 100;
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            @(negedge clk);
            #1;
            if (ph == 1 && seg_cnt == 2) found = 1;
        end
        chk("G_found_xfer", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        chk("G_pre_active", 32'(grant_active), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("G_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("G_rst_req_ready", 32'(req_ready), 32'd0);
        chk("G_rst_grant_active", 32'(grant_active), 32'd0);
        chk("G_rst_grant_id", 32'(grant_id), 32'd0);
        chk("G_rst_tx_data", 32'(tx_data), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (500) @(posedge clk);

        rand_en = '0;
        wait_quiet(4000, "H_quiet");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
